seg7_rx_monitor: RTL

//  Receive side of the seven-segment display interface. It samples a 7-bit segment bus as

---
 rtl/seg7_rx_pkg.sv | 27 ++
 rtl/seg7_rx_glyph_decode.sv | 41 ++++
 rtl/seg7_rx_monitor.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg7_rx_pkg.sv
// Shared constants for the seven-segment receive monitor: bus widths,
// the glyph table (including the tailed 6/9 variants) and digit stepping.
package seg7_rx_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;

  // Segment order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] GLYPH_0     = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'h67;
  localparam logic [SEG_W-1:0] GLYPH_6_ALT = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_9_ALT = 7'h6F;

  // Decimal successor with 9 -> 0 wrap
  function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_rx_glyph_decode.sv
// Combinational glyph decoder: segment pattern -> {legal, BCD digit}.
// Build option SEG7_RX_ALT_GLYPH_EN additionally accepts the tailed 6 (7D)
// and tailed 9 (6F) glyphs; without it those patterns are illegal.
module seg7_glyph_decode
  import seg7_rx_pkg::*;
(
  input  logic [SEG_W-1:0]   pattern_i,
  output logic               legal_o,
  output logic [DIGIT_W-1:0] digit_o
);

`ifdef SEG7_RX_ALT_GLYPH_EN
  localparam bit ALT_EN = 1'b1;
`else
  localparam bit ALT_EN = 1'b0;
`endif

  // Table lookup; anything outside the glyph set is flagged illegal with digit 0
  always_comb begin
    legal_o = 1'b1;
    digit_o = '0;
    case (pattern_i)
      GLYPH_0: digit_o = 4'd0;
      GLYPH_1: digit_o = 4'd1;
      GLYPH_2: digit_o = 4'd2;
      GLYPH_3: digit_o = 4'd3;
      GLYPH_4: digit_o = 4'd4;
      GLYPH_5: digit_o = 4'd5;
      GLYPH_6: digit_o = 4'd6;
      GLYPH_7: digit_o = 4'd7;
      GLYPH_8: digit_o = 4'd8;
      GLYPH_9: digit_o = 4'd9;
      default: begin
        if (ALT_EN && pattern_i == GLYPH_6_ALT)      digit_o = 4'd6;
        else if (ALT_EN && pattern_i == GLYPH_9_ALT) digit_o = 4'd9;
        else                                         legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_rx_monitor.sv
// Seven-segment receive monitor: 2-flop synchroniser, stability filter,
// glyph decode, 0..9 sequence checker and inter-change period counter.
// Build option SEG7_RX_ALT_GLYPH_EN (in the decoder) enables tailed 6/9.
module seg7_rx_monitor
  import seg7_rx_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [SEG_W-1:0]    seg_in,
  input  logic                clr,
  output logic [DIGIT_W-1:0]  digit,
  output logic                digit_valid,
  output logic                change_stb,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                seq_err,
  output logic                pat_err
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0]   STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;

  logic [SEG_W-1:0]    s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, acc_q, acc_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic                dvalid_q, dvalid_d, stb_q, stb_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic                pvalid_q, pvalid_d, armed_q, armed_d;
  logic                seq_q, seq_d, pat_q, pat_d;
  logic                accept, dec_legal;
  logic [DIGIT_W-1:0]  dec_digit;

  seg7_glyph_decode u_dec (
    .pattern_i (cand_q),
    .legal_o   (dec_legal),
    .digit_o   (dec_digit)
  );

  // A candidate is taken once it has matched the synchroniser for
  // STABLE_CYCLES consecutive samples and differs from the last accepted one
  assign accept = (s2_q == cand_q) && (stab_q == STAB_MAX) && (cand_q != acc_q);

  // Next-state logic for synchroniser, filter, checker and period counter
  always_comb begin
    s1_d     = seg_in;
    s2_d     = s1_q;
    cand_d   = cand_q;
    stab_d   = stab_q;
    acc_d    = acc_q;
    digit_d  = digit_q;
    dvalid_d = dvalid_q;
    stb_d    = accept;
    seq_d    = seq_q;
    pat_d    = pat_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    armed_d  = armed_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    if (s2_q != cand_q) begin
      cand_d = s2_q;
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end

    if (accept) begin
      acc_d = cand_q;
      if (dec_legal) begin
        digit_d  = dec_digit;
        dvalid_d = 1'b1;
        // only checked when the previous accepted pattern was itself legal
        if (dvalid_q && dec_digit != next_digit(digit_q)) seq_d = 1'b1;
      end else begin
        dvalid_d = 1'b0;
        pat_d    = 1'b1;
      end
      period_d = cnt_q;
      cnt_d    = PERIOD_W'(1);
      if (armed_q) pvalid_d = 1'b1;
      armed_d  = 1'b1;
    end

    // clr wins over anything set this cycle; digit/acc keep tracking
    if (clr) begin
      seq_d    = 1'b0;
      pat_d    = 1'b0;
      period_d = '0;
      pvalid_d = 1'b0;
      armed_d  = 1'b0;
      cnt_d    = '0;
    end
  end

  // All state, including the synchroniser, freezes while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stab_q   <= '0;
      acc_q    <= '0;
      digit_q  <= '0;
      dvalid_q <= 1'b0;
      stb_q    <= 1'b0;
      seq_q    <= 1'b0;
      pat_q    <= 1'b0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (ena) begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      acc_q    <= acc_d;
      digit_q  <= digit_d;
      dvalid_q <= dvalid_d;
      stb_q    <= stb_d;
      seq_q    <= seq_d;
      pat_q    <= pat_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = dvalid_q;
  assign change_stb   = stb_q;
  assign period       = period_q;
  assign period_valid = pvalid_q;
  assign seq_err      = seq_q;
  assign pat_err      = pat_q;

endmodule
